// File: rtl/iir_pkg.sv
// Shared types, default coefficients and the fixed-point helper for iir_mc.
package iir_pkg;

  typedef enum logic [1:0] {
    S_READ,
    S_CALC,
    S_WRITE
  } state_t;

  localparam int unsigned FRAC_BITS_DEFAULT = 10;
  localparam int          X0_DEFAULT        = 178;
  localparam int          X1_DEFAULT        = 178;
  localparam int          Y1_DEFAULT        = -666;

  // Widest product the helper accepts; callers sign-extend into it and truncate the result.
  localparam int unsigned PROD_MAX = 128;

  // Divide by 2^frac_bits truncating toward zero: bias negatives before the arithmetic shift.
  function automatic logic signed [PROD_MAX-1:0] dequantize(
    input logic signed [PROD_MAX-1:0] p,
    input int unsigned                frac_bits
  );
    logic signed [PROD_MAX-1:0] bias;
    bias = signed'((PROD_MAX'(1) << frac_bits) - PROD_MAX'(1));
    if (p[PROD_MAX-1]) begin
      return (p + bias) >>> frac_bits;
    end
    return p >>> frac_bits;
  endfunction

endpackage

// File: rtl/iir_mc_fifo.sv
// First-word-fall-through FIFO with asynchronous reset. DEPTH must be a power of two (>= 2).
module iir_mc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push into a full FIFO is taken when the same edge pops, freeing the head slot.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || rd_en);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iir_mc.sv
// Multichannel first-order IIR: input FIFO -> 3-cycle read/multiply/write core -> output FIFO.
module iir_mc
  import iir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEFAULT,
  parameter int          X0         = X0_DEFAULT,
  parameter int          X1         = X1_DEFAULT,
  parameter int          Y1         = Y1_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_wr_en,
  output logic                  in_full,
  input  logic                  clear,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_rd_en,
  output logic                  out_empty
);

  localparam int unsigned PW     = 2 * DATA_WIDTH;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Round history depth up to the index range so ch_idx can never select past the array.
  localparam int unsigned HIST_N = 2 ** CH_W;

  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd;
  logic                  out_full;
  logic                  out_wr;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic                         bypass_q;
  logic [CH_W-1:0]              ch_idx;
  logic signed [PW-1:0]         p0_q;
  logic signed [PW-1:0]         p1_q;
  logic signed [PW-1:0]         p2_q;
  logic signed [DATA_WIDTH-1:0] x_prev [HIST_N];
  logic signed [DATA_WIDTH-1:0] y_prev [HIST_N];
  logic signed [DATA_WIDTH-1:0] y_new;

  iir_mc_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .wr_en (in_wr_en),
    .full  (in_full),
    .dout  (in_dout),
    .rd_en (in_rd),
    .empty (in_empty)
  );

  iir_mc_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .din   (y_new),
    .wr_en (out_wr),
    .full  (out_full),
    .dout  (dout),
    .rd_en (out_rd_en),
    .empty (out_empty)
  );

  // Pop only when the result is guaranteed a slot; clear suppresses both FIFO strobes.
  assign in_rd  = (state == S_READ) && !in_empty && !out_full && !clear;
  assign out_wr = (state == S_WRITE) && !clear;

  // Sum of the three dequantised products, each wrapped to DATA_WIDTH.
  always_comb begin
    y_new = x_q;
    if (!bypass_q) begin
      y_new = DATA_WIDTH'(dequantize(PROD_MAX'(p0_q), FRAC_BITS))
            + DATA_WIDTH'(dequantize(PROD_MAX'(p1_q), FRAC_BITS))
            - DATA_WIDTH'(dequantize(PROD_MAX'(p2_q), FRAC_BITS));
    end
  end

  // Read / multiply / write sequencer with per-channel history; clear wins over every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_READ;
      x_q      <= '0;
      bypass_q <= 1'b0;
      ch_idx   <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      for (int i = 0; i < int'(HIST_N); i++) begin
        x_prev[i] <= '0;
        y_prev[i] <= '0;
      end
    end else if (clear) begin
      state  <= S_READ;
      ch_idx <= '0;
      for (int i = 0; i < int'(HIST_N); i++) begin
        x_prev[i] <= '0;
        y_prev[i] <= '0;
      end
    end else begin
      unique case (state)
        S_READ: begin
          if (in_rd) begin
            x_q      <= in_dout;
            bypass_q <= bypass;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          p0_q  <= PW'(x_q) * PW'(X0);
          p1_q  <= PW'(x_prev[ch_idx]) * PW'(X1);
          p2_q  <= PW'(y_prev[ch_idx]) * PW'(Y1);
          state <= S_WRITE;
        end
        S_WRITE: begin
          x_prev[ch_idx] <= x_q;
          y_prev[ch_idx] <= y_new;
          ch_idx         <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
          state          <= S_READ;
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mc.sv
// Scoreboard bench for iir_mc: one NUM_CH=1 and one NUM_CH=2 instance share all stimulus.
module tb_iir_mc;

  localparam int     DW    = 32;
  localparam int     DEPTH = 16;
  localparam longint C_X0  = 178;
  localparam longint C_X1  = 178;
  localparam longint C_Y1  = -666;
  localparam longint SCALE = 1024;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          clear     = 1'b0;
  logic          bypass    = 1'b0;
  logic          in_wr_en  = 1'b0;
  logic          out_rd_en = 1'b0;
  logic [DW-1:0] din       = '0;
  logic          in_full_a, in_full_b, out_empty_a, out_empty_b;
  logic [DW-1:0] dout_a, dout_b;

  int     n_cmp   = 0;
  int     n_fail  = 0;
  int     dropped = 0;
  longint xp [2][2];
  longint yp [2][2];
  int     chn [2];
  int     q_a [$];
  int     q_b [$];

  always #5 clock = ~clock;

  iir_mc #(.DATA_WIDTH(DW), .NUM_CH(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full_a),
    .clear(clear), .bypass(bypass), .dout(dout_a), .out_rd_en(out_rd_en),
    .out_empty(out_empty_a)
  );

  iir_mc #(.DATA_WIDTH(DW), .NUM_CH(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full_b),
    .clear(clear), .bypass(bypass), .dout(dout_b), .out_rd_en(out_rd_en),
    .out_empty(out_empty_b)
  );

  // Reference model: integer division truncates toward zero; int'() wraps to 32 bits.
  function automatic longint dq(longint p);
    return p / SCALE;
  endfunction

  function automatic int model_y(int inst, logic [31:0] x);
    longint xs;
    int     y;
    int     c;
    c  = chn[inst];
    xs = longint'($signed(x));
    if (bypass) y = int'(xs);
    else y = int'(longint'(int'(dq(C_X0 * xs))) + longint'(int'(dq(C_X1 * xp[inst][c])))
                  - longint'(int'(dq(C_Y1 * yp[inst][c]))));
    xp[inst][c] = xs;
    yp[inst][c] = longint'(y);
    chn[inst]   = (chn[inst] + 1) % ((inst == 0) ? 1 : 2);
    return y;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      chn[i] = 0;
      for (int c = 0; c < 2; c++) begin
        xp[i][c] = 0;
        yp[i][c] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clock);
      if (!reset && out_rd_en && !out_empty_a) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_extra: got %h, required no output", dout_a);
        end else begin
          e = q_a.pop_front();
          if (dout_a !== e) begin
            n_fail++;
            $display("FAIL sb_a: got %h, required %h", dout_a, e);
          end
        end
      end
      if (!reset && out_rd_en && !out_empty_b) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_extra: got %h, required no output", dout_b);
        end else begin
          e = q_b.pop_front();
          if (dout_b !== e) begin
            n_fail++;
            $display("FAIL sb_b: got %h, required %h", dout_b, e);
          end
        end
      end
    end
  endtask

  // Present one word for one cycle; expectations only for instances that accept it.
  task automatic drive(input logic [31:0] w, input bit expect_out);
    din      = w;
    in_wr_en = 1'b1;
    if (in_full_a) dropped++;
    if (expect_out) begin
      if (!in_full_a) q_a.push_back(model_y(0, w));
      if (!in_full_b) q_b.push_back(model_y(1, w));
    end
    cyc();
    in_wr_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    for (int i = 0; i < 12 && in_full_a; i++) cyc();
    drive(w, 1'b1);
  endtask

  task automatic drain();
    int t;
    t         = 0;
    out_rd_en = 1'b1;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 3000) begin
      cyc();
      t++;
    end
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0", q_a.size(), q_b.size());
    end
    repeat (6) cyc();
    check("drained_empty_a", longint'(out_empty_a), 1);
    check("drained_empty_b", longint'(out_empty_b), 1);
    out_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    model_clear();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_full_a", longint'(in_full_a), 0);
    check("rst_in_full_b", longint'(in_full_b), 0);
    check("rst_out_empty_a", longint'(out_empty_a), 1);
    check("rst_out_empty_b", longint'(out_empty_b), 1);
    check("rst_dout_a", longint'(dout_a), 0);
    check("rst_dout_b", longint'(dout_b), 0);
    reset = 1'b0;
    cyc();

    // Step and negative input.
    push(32'h0000_0400);
    push(32'h0000_0400);
    drain();
    do_reset();
    push(32'hFFFF_FC00);
    drain();

    // Interleave.
    do_reset();
    push(32'd1024); push(32'd0); push(32'd1024); push(32'd0);
    drain();

    // Backpressure: 32 words fit (16 per FIFO), the last two must bounce off in_full.
    do_reset();
    dropped = 0;
    for (int i = 0; i < 2 * DEPTH + 2; i++) push($urandom);
    check("bp_in_full", longint'(in_full_a), 1);
    check("bp_dropped", dropped, 2);
    check("bp_out_not_empty", longint'(out_empty_a), 0);
    drain();

    // Clear: history flushed, in-flight sample dropped, next word restarts on ch0.
    do_reset();
    push(32'd1024); push(32'd5000); push(32'd1024);
    drain();
    drive(32'd7777, 1'b0);
    cyc();
    clear = 1'b1;
    model_clear();
    cyc();
    clear = 1'b0;
    repeat (5) cyc();
    check("clear_dropped_a", longint'(out_empty_a), 1);
    push(32'd1024);
    drain();

    // Bypass, then return to filtering with bypassed history.
    do_reset();
    bypass = 1'b1;
    push(32'h1234_5678);
    drain();
    bypass = 1'b0;
    push(32'd1024);
    drain();

    // Asynchronous reset while a sample sits in S_CALC and the output FIFO holds data.
    do_reset();
    push(32'd1024); push(32'd2048); push(32'd3072);
    repeat (12) cyc();
    drive(32'd1024, 1'b0);
    cyc();
    reset = 1'b1;
    #1;
    check("midrst_out_empty_a", longint'(out_empty_a), 1);
    check("midrst_out_empty_b", longint'(out_empty_b), 1);
    check("midrst_in_full_a", longint'(in_full_a), 0);
    check("midrst_dout_a", longint'(dout_a), 0);
    q_a.delete();
    q_b.delete();
    model_clear();
    cyc();
    reset = 1'b0;
    cyc();
    push(32'd1024);
    drain();

    // Randomised traffic in segments of constant bypass.
    for (int s = 0; s < 4; s++) begin
      bypass = 1'($urandom_range(0, 1));
      for (int i = 0; i < 150; i++) begin
        out_rd_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1 && !in_full_a) drive($urandom, 1'b1);
        else cyc();
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
